// File: rtl/fmul_pipe.sv
// Four-stage pipelined floating-point multiplier with round-to-nearest-even,
// flush-to-zero of subnormals and IEEE special-case handling.
// Each stage carries its own valid bit; a stage loads whenever it is empty
// or its current contents are moving forward, so bubbles collapse.
module fmul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] rs1,
    input  logic [EXP_W+MAN_W:0] rs2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out,
    output logic [3:0]           flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS   = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Stage registers
    logic                 s1Valid_q, s2Valid_q, s3Valid_q, s4Valid_q;
    logic                 s1Sign_q, s2Sign_q, s3Sign_q;
    logic                 s1Special_q, s2Special_q, s3Special_q;
    logic [W-1:0]         s1SpecRes_q, s2SpecRes_q, s3SpecRes_q;
    logic                 s1Invalid_q, s2Invalid_q, s3Invalid_q;
    logic [EXP_W-1:0]     s1ExpA_q, s1ExpB_q;
    logic [MAN_W-1:0]     s1FracA_q, s1FracB_q;
    logic signed [EW-1:0] s2Exp_q, s3Exp_q;
    logic [PW-1:0]        s2Prod_q;
    logic [MAN_W-1:0]     s3Frac_q;
    logic                 s3Guard_q, s3Sticky_q;
    logic [W-1:0]         s4Out_q;
    logic [3:0]           s4Flags_q;

    // Next-state values
    logic                 s1Special_d, s1Invalid_d;
    logic [W-1:0]         s1SpecRes_d;
    logic signed [EW-1:0] s2Exp_d, s3Exp_d;
    logic [PW-1:0]        s2Prod_d;
    logic [MAN_W-1:0]     s3Frac_d;
    logic                 s3Guard_d, s3Sticky_d;
    logic [W-1:0]         s4Out_d;
    logic [3:0]           s4Flags_d;

    logic                 load1, load2, load3, load4;
    logic                 roundInc, roundCarry;
    logic [MAN_W-1:0]     roundFrac;
    logic signed [EW-1:0] roundExp;

    // Operand field decode
    logic [EXP_W-1:0] expA, expB;
    logic [MAN_W-1:0] fracA, fracB;
    logic             signP;
    logic             aZero, bZero, aInf, bInf, aNan, bNan, aSnan, bSnan;

    assign expA  = rs1[W-2:MAN_W];
    assign expB  = rs2[W-2:MAN_W];
    assign fracA = rs1[MAN_W-1:0];
    assign fracB = rs2[MAN_W-1:0];
    assign signP = rs1[W-1] ^ rs2[W-1];
    assign aZero = (expA == '0);
    assign bZero = (expB == '0);
    assign aInf  = (expA == '1) && (fracA == '0);
    assign bInf  = (expB == '1) && (fracB == '0);
    assign aNan  = (expA == '1) && (fracA != '0);
    assign bNan  = (expB == '1) && (fracB != '0);
    assign aSnan = aNan && !fracA[MAN_W-1];
    assign bSnan = bNan && !fracB[MAN_W-1];

    // Backpressure chain: each stage may load when empty or when draining forward
    always_comb begin
        load4 = !s4Valid_q || out_ready;
        load3 = !s3Valid_q || load4;
        load2 = !s2Valid_q || load3;
        load1 = !s1Valid_q || load2;
    end

    assign in_ready  = load1;
    assign out_valid = s4Valid_q;
    assign out       = s4Out_q;
    assign flags     = s4Flags_q;

    // Classify operands and decide any special-case result up front
    always_comb begin
        s1Special_d = 1'b0;
        s1Invalid_d = 1'b0;
        s1SpecRes_d = '0;
        if (aNan || bNan || (aInf && bZero) || (aZero && bInf)) begin
            s1Special_d = 1'b1;
            s1SpecRes_d = QNAN;
            s1Invalid_d = aSnan || bSnan || (aInf && bZero) || (aZero && bInf);
        end else if (aInf || bInf) begin
            s1Special_d = 1'b1;
            s1SpecRes_d = {signP, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (aZero || bZero) begin
            s1Special_d = 1'b1;
            s1SpecRes_d = {signP, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        end
    end

    // Stage 1 register: unpacked fields and special-case decision
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1Valid_q   <= 1'b0;
            s1Sign_q    <= 1'b0;
            s1ExpA_q    <= '0;
            s1ExpB_q    <= '0;
            s1FracA_q   <= '0;
            s1FracB_q   <= '0;
            s1Special_q <= 1'b0;
            s1SpecRes_q <= '0;
            s1Invalid_q <= 1'b0;
        end else if (load1) begin
            s1Valid_q   <= in_valid;
            s1Sign_q    <= signP;
            s1ExpA_q    <= expA;
            s1ExpB_q    <= expB;
            s1FracA_q   <= fracA;
            s1FracB_q   <= fracB;
            s1Special_q <= s1Special_d;
            s1SpecRes_q <= s1SpecRes_d;
            s1Invalid_q <= s1Invalid_d;
        end
    end

    // Biased exponent sum and full significand product
    always_comb begin
        s2Exp_d  = $signed({2'b00, s1ExpA_q}) + $signed({2'b00, s1ExpB_q}) - BIAS;
        s2Prod_d = PW'({1'b1, s1FracA_q}) * PW'({1'b1, s1FracB_q});
    end

    // Stage 2 register: exponent sum and raw product
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s2Valid_q   <= 1'b0;
            s2Sign_q    <= 1'b0;
            s2Exp_q     <= '0;
            s2Prod_q    <= '0;
            s2Special_q <= 1'b0;
            s2SpecRes_q <= '0;
            s2Invalid_q <= 1'b0;
        end else if (load2) begin
            s2Valid_q   <= s1Valid_q;
            s2Sign_q    <= s1Sign_q;
            s2Exp_q     <= s2Exp_d;
            s2Prod_q    <= s2Prod_d;
            s2Special_q <= s1Special_q;
            s2SpecRes_q <= s1SpecRes_q;
            s2Invalid_q <= s1Invalid_q;
        end
    end

    // Normalise a product in [2,4) down by one and extract fraction, guard and sticky
    always_comb begin
        s3Exp_d    = s2Exp_q;
        s3Frac_d   = s2Prod_q[PW-3:MAN_W];
        s3Guard_d  = s2Prod_q[MAN_W-1];
        s3Sticky_d = |s2Prod_q[MAN_W-2:0];
        if (s2Prod_q[PW-1]) begin
            s3Exp_d    = s2Exp_q + E_ONE;
            s3Frac_d   = s2Prod_q[PW-2:MAN_W+1];
            s3Guard_d  = s2Prod_q[MAN_W];
            s3Sticky_d = |s2Prod_q[MAN_W-1:0];
        end
    end

    // Stage 3 register: normalised fraction with rounding bits
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s3Valid_q   <= 1'b0;
            s3Sign_q    <= 1'b0;
            s3Exp_q     <= '0;
            s3Frac_q    <= '0;
            s3Guard_q   <= 1'b0;
            s3Sticky_q  <= 1'b0;
            s3Special_q <= 1'b0;
            s3SpecRes_q <= '0;
            s3Invalid_q <= 1'b0;
        end else if (load3) begin
            s3Valid_q   <= s2Valid_q;
            s3Sign_q    <= s2Sign_q;
            s3Exp_q     <= s3Exp_d;
            s3Frac_q    <= s3Frac_d;
            s3Guard_q   <= s3Guard_d;
            s3Sticky_q  <= s3Sticky_d;
            s3Special_q <= s2Special_q;
            s3SpecRes_q <= s2SpecRes_q;
            s3Invalid_q <= s2Invalid_q;
        end
    end

    // Round to nearest even, then saturate to inf or flush to zero at the range ends
    always_comb begin
        roundInc                = s3Guard_q && (s3Sticky_q || s3Frac_q[0]);
        {roundCarry, roundFrac} = {1'b0, s3Frac_q} + {{MAN_W{1'b0}}, roundInc};
        roundExp                = s3Exp_q + (roundCarry ? E_ONE : E_ZERO);
        s4Out_d                 = {s3Sign_q, roundExp[EXP_W-1:0], roundFrac};
        s4Flags_d               = {3'b000, s3Guard_q || s3Sticky_q};
        if (s3Special_q) begin
            s4Out_d   = s3SpecRes_q;
            s4Flags_d = {s3Invalid_q, 3'b000};
        end else if (roundExp >= E_MAX) begin
            s4Out_d   = {s3Sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            s4Flags_d = 4'b0101;
        end else if (roundExp <= E_ZERO) begin
            s4Out_d   = {s3Sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            s4Flags_d = 4'b0011;
        end
    end

    // Stage 4 register: packed result held until the consumer takes it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s4Valid_q <= 1'b0;
            s4Out_q   <= '0;
            s4Flags_q <= '0;
        end else if (load4) begin
            s4Valid_q <= s3Valid_q;
            s4Out_q   <= s4Out_d;
            s4Flags_q <= s4Flags_d;
        end
    end

endmodule

// File: tb/tb_fmul_pipe.sv
// Testbench for fmul_pipe: FP32 directed vectors, a stalled stream,
// mid-stream asynchronous reset, and an FP16 instance.
module tb_fmul_pipe;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expOut;
        logic [3:0]  expFlags;
        string       name;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] rs1, rs2, outData;
    logic [3:0]  flags;

    logic        hInValid, hInReady, hOutValid, hOutReady;
    logic [15:0] hRs1, hRs2, hOut;
    logic [3:0]  hFlags;

    int   checks;
    int   errors;
    vec_t vecs[24];
    int   vecCount;

    fmul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(outData), .flags(flags)
    );

    fmul_pipe #(.EXP_W(5), .MAN_W(10)) dutHalf (
        .clk(clk), .resetn(resetn),
        .in_valid(hInValid), .in_ready(hInReady),
        .rs1(hRs1), .rs2(hRs2),
        .out_valid(hOutValid), .out_ready(hOutReady),
        .out(hOut), .flags(hFlags)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e, input logic [3:0] f, input string name);
        vecs[vecCount].a        = a;
        vecs[vecCount].b        = b;
        vecs[vecCount].expOut   = e;
        vecs[vecCount].expFlags = f;
        vecs[vecCount].name     = name;
        vecCount++;
    endtask

    // Single FP32 op into an empty pipe; entered and left at posedge+1
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expOut, input logic [3:0] expFlags,
                                 input string name);
        int lat;
        rs1       = a;
        rs2       = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput({name, "_inReady"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'd4);
        checkOutput(name, outData, expOut);
        checkOutput({name, "_flags"}, 32'(flags), 32'(expFlags));
        @(posedge clk);
        #1;
    endtask

    // Single FP16 op into the half-precision instance
    task automatic applyHalf(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] expOut, input logic [3:0] expFlags,
                             input string name);
        int lat;
        hRs1      = a;
        hRs2      = b;
        hInValid  = 1'b1;
        hOutReady = 1'b1;
        @(posedge clk);
        #1;
        hInValid = 1'b0;
        lat      = 1;
        while (!hOutValid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'd4);
        checkOutput(name, 32'(hOut), 32'(expOut));
        checkOutput({name, "_flags"}, 32'(hFlags), 32'(expFlags));
        @(posedge clk);
        #1;
    endtask

    // Eight back-to-back ops with the consumer stalled for cycles 3..8
    task automatic streamTest();
        logic [31:0] streamA[8];
        logic [31:0] streamExp[8];
        logic [31:0] prevOut;
        bit          prevStall;
        bit          sawFull;
        int          sent, recv, cyc, inFlight;
        streamA   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                      32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        streamExp = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                      32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};
        prevOut   = '0;
        prevStall = 1'b0;
        sawFull   = 1'b0;
        sent      = 0;
        recv      = 0;
        cyc       = 0;
        while (recv < 8 && cyc < 60) begin
            out_ready = !(cyc >= 3 && cyc <= 8);
            in_valid  = (sent < 8);
            rs1       = (sent < 8) ? streamA[sent] : 32'h0;
            rs2       = 32'h40000000;
            #1;
            inFlight = sent - recv;
            checkOutput("stream_inReady", 32'(in_ready), 32'((inFlight < 4) || out_ready));
            if (!in_ready) sawFull = 1'b1;
            if (prevStall) begin
                checkOutput("stream_holdValid", 32'(out_valid), 32'd1);
                checkOutput("stream_holdData", outData, prevOut);
            end
            if (out_valid && out_ready) begin
                checkOutput("stream_order", outData, streamExp[recv]);
                recv++;
            end
            prevStall = out_valid && !out_ready;
            prevOut   = outData;
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("stream_count", 32'(recv), 32'd8);
        checkOutput("stream_sawFull", 32'(sawFull), 32'd1);
        checkOutput("stream_drained", 32'(out_valid), 32'd0);
    endtask

    // Reset with three ops in flight, then confirm a clean restart
    task automatic resetTest();
        int seen;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            rs1      = 32'h40400000;
            rs2      = 32'h40000000;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_preValid", 32'(out_valid), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("rst_asyncValid", 32'(out_valid), 32'd0);
        checkOutput("rst_asyncOut", outData, 32'h0);
        checkOutput("rst_asyncFlags", 32'(flags), 32'd0);
        @(posedge clk);
        #1;
        resetn    = 1'b1;
        out_ready = 1'b1;
        seen      = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checkOutput("rst_noStale", 32'(seen), 32'd0);
        applyStimulus(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, "rst_after");
    endtask

    initial begin
        clk       = 1'b0;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rs1       = '0;
        rs2       = '0;
        hInValid  = 1'b0;
        hOutReady = 1'b1;
        hRs1      = '0;
        hRs2      = '0;
        checks    = 0;
        errors    = 0;
        vecCount  = 0;

        addVec(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, "mul1p5x2");
        addVec(32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, "negMul");
        addVec(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, "rneSticky");
        addVec(32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, "overflow");
        addVec(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, "underflow");
        addVec(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, "infZero");
        addVec(32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, "sNaN");
        addVec(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000, "qNaN");
        addVec(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, "tieUpOdd");
        addVec(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001, "tieDownEven");
        addVec(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001, "normShift");
        addVec(32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000, "minNormal");
        addVec(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000, "maxNormal");
        addVec(32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, "infFinite");
        addVec(32'hFF800000, 32'h7F800000, 32'hFF800000, 4'b0000, "infInf");
        addVec(32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, "negZero");
        addVec(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, "dazSubnormal");
        addVec(32'h80000000, 32'hFF800000, 32'h7FC00000, 4'b1000, "zeroInf");
        addVec(32'h7FC00000, 32'hFF800001, 32'h7FC00000, 4'b1000, "qNaNsNaN");

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outValid", 32'(out_valid), 32'd0);
        checkOutput("reset_out", outData, 32'h0);
        checkOutput("reset_flags", 32'(flags), 32'd0);
        checkOutput("reset_halfValid", 32'(hOutValid), 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_inReady", 32'(in_ready), 32'd1);

        for (int i = 0; i < vecCount; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].expOut, vecs[i].expFlags, vecs[i].name);
        end

        streamTest();
        resetTest();

        applyHalf(16'h3E00, 16'h4000, 16'h4200, 4'b0000, "half_mul");
        applyHalf(16'h7800, 16'h4000, 16'h7C00, 4'b0101, "half_overflow");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
